// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: operation codes, FSM states and flag bit positions.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SHL,
    ALU_SHR,
    ALU_MUL
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StMul,
    StDone
  } alu_state_e;

  // Bit positions within the {Z,C,N} flag vector.
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagN = 0;

endpackage

// File: rtl/alu_seq_if.sv
// Request/status bundle between the sequencer and the ALU; master drives requests.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 8
);

  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  alu_seq_pkg::alu_op_e   op;
  logic                   start;
  logic                   out_en;
  logic                   busy;
  logic                   done;
  logic [2:0]             flags;

  modport master (
    output a, b, op, start, out_en,
    input  busy, done, flags
  );

  modport slave (
    input  a, b, op, start, out_en,
    output busy, done, flags
  );

endinterface

// File: rtl/alu_mul8.sv
// Shift-add multiplier: one partial product per step, WIDTH steps per multiply.
module alu_mul8 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 last
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CntW-1:0]    cnt_q;

  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) begin
      acc_d = acc_q + mcand_q;
    end
  end

  // Exposes the accumulator including the current step so the final product is usable on the
  // same edge that completes the last step.
  assign product = acc_d;
  assign last    = step && (cnt_q == CntW'(WIDTH - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (load) begin
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
      cnt_q    <= '0;
    end else if (step) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: latches operands on start, executes single-cycle ops or a shift-add MUL,
// holds result/flags and drives the result onto the shared bus when enabled.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  alu_seq_if.slave          bus,
  output logic [WIDTH-1:0]  out
);

  alu_state_e         state_q, state_d;
  alu_op_e            op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [2:0]         flags_q, flags_d;
  logic               load, step, last, wr;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH:0]     alu_wide;

  alu_mul8 #(.WIDTH(WIDTH)) u_mul (
    .clock   (clock),
    .reset   (reset),
    .load    (load),
    .step    (step),
    .a       (bus.a),
    .b       (bus.b),
    .product (product),
    .last    (last)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    wr      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = (bus.op == ALU_MUL) ? StMul : StExec;
        end
      end
      StExec: begin
        wr      = 1'b1;
        state_d = StDone;
      end
      StMul: begin
        step = 1'b1;
        if (last) begin
          wr      = 1'b1;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // {carry, result}; carry comes out of the WIDTH+1-bit arithmetic.
  always_comb begin
    alu_wide = '0;
    unique case (op_q)
      ALU_ADD: alu_wide = {1'b0, a_q} + {1'b0, b_q};
      ALU_SUB: alu_wide = {1'b0, a_q} - {1'b0, b_q};
      ALU_AND: alu_wide = {1'b0, a_q & b_q};
      ALU_OR:  alu_wide = {1'b0, a_q | b_q};
      ALU_XOR: alu_wide = {1'b0, a_q ^ b_q};
      ALU_SHL: alu_wide = {a_q, 1'b0};
      ALU_SHR: alu_wide = {a_q[0], 1'b0, a_q[WIDTH-1:1]};
      ALU_MUL: alu_wide = {|product[2*WIDTH-1:WIDTH], product[WIDTH-1:0]};
      default: alu_wide = '0;
    endcase
  end

  always_comb begin
    result_d       = alu_wide[WIDTH-1:0];
    flags_d        = '0;
    flags_d[FlagZ] = (result_d == '0);
    flags_d[FlagC] = alu_wide[WIDTH];
    flags_d[FlagN] = result_d[WIDTH-1];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= ALU_ADD;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        op_q <= bus.op;
        a_q  <= bus.a;
        b_q  <= bus.b;
      end
      if (wr) begin
        result_q <= result_d;
        flags_q  <= flags_d;
      end
    end
  end

  assign bus.busy  = (state_q != StIdle);
  assign bus.done  = (state_q == StDone);
  assign bus.flags = flags_q;
  assign out       = bus.out_en ? result_q : 'z;

endmodule
